// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave arbiter for the picorv32 native
// memory interface (valid/ready handshake).
//   clk, reset            system clock, synchronous active-high reset
//   m0_* / m1_*           master request ports (m0 = CPU, m1 = secondary master)
//   s_*                   slave request port toward the address-decoded fabric
//   grant                 one-hot current owner, 00 when idle
//   bus_err               one-cycle pulse when the watchdog ends a hung transfer
//   err_count             saturating count of watchdog terminations
// The grant is held for a whole transfer. Every transfer ends with one IDLE
// cycle, which lets the round-robin pointer take effect between transfers.
module mem_bus_arbiter #(
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        bus_err,
    output logic [7:0]  err_count
);

    localparam int unsigned CNT_W  = 8;
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    // Timeouts beyond the counter range clamp to the largest reachable value.
    localparam logic [CNT_W-1:0] TO_VAL = (TIMEOUT_CYCLES > 255) ? 8'hFF
                                                                 : CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic             rr_last;      // 1 = master 1 owned the last completed transfer
    logic [CNT_W-1:0] counter;

    logic       busy;
    logic       own_valid;
    logic       done;
    logic       timeout;
    logic [1:0] winner;

    // Owner still requesting; 0 while idle because grant is 00.
    assign own_valid = (grant[0] & m0_valid) | (grant[1] & m1_valid);

    // Gating with reset keeps every output at 0 while reset is held.
    assign busy    = (state == BUSY) && !reset;
    assign done    = busy && own_valid && s_ready;
    assign timeout = busy && own_valid && !s_ready && TO_EN && (counter == TO_VAL);

    // Arbitration decision for the IDLE cycle.
    always_comb begin
        winner = 2'b00;
        if (m0_valid && !m1_valid) begin
            winner = 2'b01;
        end else if (m1_valid && !m0_valid) begin
            winner = 2'b10;
        end else if (m0_valid && m1_valid) begin
            if (FIXED_PRIO || rr_last) begin
                winner = 2'b01;
            end else begin
                winner = 2'b10;
            end
        end
    end

    // Slave-side request mux and master-side response demux.
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        bus_err  = timeout;

        if (busy) begin
            s_valid = own_valid && !timeout;
            if (grant[1]) begin
                s_instr = m1_instr;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_instr = m0_instr;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end

        if (done || timeout) begin
            if (grant[0]) begin
                m0_ready = 1'b1;
                m0_rdata = done ? s_rdata : ERR_RDATA;
            end
            if (grant[1]) begin
                m1_ready = 1'b1;
                m1_rdata = done ? s_rdata : ERR_RDATA;
            end
        end
    end

    // State, grant, round-robin pointer, watchdog and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            rr_last   <= 1'b1;
            counter   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (winner != 2'b00) begin
                        grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_valid) begin
                        // Owner withdrew: abandon without moving the pointer.
                        state   <= IDLE;
                        grant   <= 2'b00;
                        counter <= '0;
                    end else if (s_ready || timeout) begin
                        state   <= IDLE;
                        grant   <= 2'b00;
                        counter <= '0;
                        rr_last <= grant[1];
                        if (timeout && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance and a fixed-priority
// instance, each with a small slave model whose response latency is set per
// scenario. Expected responses are queued when a request is issued and popped
// by a monitor whenever the DUT raises a master ready.
module tb_mem_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'hCAFE_0001;
    localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
    localparam int NEVER = 1000;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // shared master payloads
    logic        m0_instr = 1'b1;
    logic        m1_instr = 1'b0;
    logic [31:0] m0_addr  = A0;
    logic [31:0] m1_addr  = A1;
    logic [31:0] m0_wdata = W0;
    logic [31:0] m1_wdata = W1;
    logic [3:0]  m0_wstrb = 4'h0;
    logic [3:0]  m1_wstrb = 4'hF;
    logic [31:0] srd = 32'h0;

    // round-robin instance
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        r_m0_ready, r_m1_ready, r_s_valid, r_s_instr, r_s_ready, r_bus_err;
    logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
    logic [3:0]  r_s_wstrb;
    logic [1:0]  r_grant;
    logic [7:0]  r_err_count;
    int          lat_rr = 1;
    int          cnt_rr = 0;

    // fixed-priority instance
    logic        f_m0_valid = 1'b0, f_m1_valid = 1'b0;
    logic        f_m0_ready, f_m1_ready, f_s_valid, f_s_instr, f_s_ready, f_bus_err;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
    logic [3:0]  f_s_wstrb;
    logic [1:0]  f_grant;
    logic [7:0]  f_err_count;
    int          lat_fp = 1;
    int          cnt_fp = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(4), .ERR_RDATA(ERRW)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(r_m0_ready), .m0_rdata(r_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(r_m1_ready), .m1_rdata(r_m1_rdata),
        .s_valid(r_s_valid), .s_instr(r_s_instr), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
        .s_wstrb(r_s_wstrb), .s_ready(r_s_ready), .s_rdata(srd),
        .grant(r_grant), .bus_err(r_bus_err), .err_count(r_err_count)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(4), .ERR_RDATA(ERRW)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_valid(f_m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
        .m1_valid(f_m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
        .s_valid(f_s_valid), .s_instr(f_s_instr), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_wstrb(f_s_wstrb), .s_ready(f_s_ready), .s_rdata(srd),
        .grant(f_grant), .bus_err(f_bus_err), .err_count(f_err_count)
    );

    // Slave models: ready once a granted transfer has waited lat_* cycles.
    assign r_s_ready = (r_grant != 2'b00) && (cnt_rr == lat_rr);
    assign f_s_ready = (f_grant != 2'b00) && (cnt_fp == lat_fp);

    always @(posedge clk) begin
        cnt_rr <= (r_grant != 2'b00 && !r_s_ready) ? cnt_rr + 1 : 0;
        cnt_fp <= (f_grant != 2'b00 && !f_s_ready) ? cnt_fp + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rr(input int m, input logic [31:0] d, input logic e);
        exp_t x;
        x.m = m; x.d = d; x.e = e;
        q_rr.push_back(x);
    endtask

    task automatic push_fp(input int m, input logic [31:0] d, input logic e);
        exp_t x;
        x.m = m; x.d = d; x.e = e;
        q_fp.push_back(x);
    endtask

    // Response monitor shared by both instances.
    task automatic mon(input int dut, input logic v0, input logic v1,
                       input logic r0, input logic r1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic be);
        exp_t x;
        int   m;
        if (r0) chk("m0_ready_needs_valid", 32'(v0), 32'd1);
        if (r1) chk("m1_ready_needs_valid", 32'(v1), 32'd1);
        if (r0 || r1) begin
            m = r1 ? 1 : 0;
            chk("single_ready", 32'(r0 && r1), 32'd0);
            if ((dut == 0 && q_rr.size() == 0) || (dut == 1 && q_fp.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: dut %0d master %0d got ready, expected none", dut, m);
            end else begin
                x = (dut == 0) ? q_rr.pop_front() : q_fp.pop_front();
                chk("resp_master", 32'(m), 32'(x.m));
                chk("resp_rdata", m ? d1 : d0, x.d);
                chk("resp_other_rdata", m ? d0 : d1, 32'h0);
                chk("resp_bus_err", 32'(be), 32'(x.e));
            end
        end else if (be) begin
            chk("bus_err_without_ready", 32'(be), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, m0_valid, m1_valid, r_m0_ready, r_m1_ready, r_m0_rdata, r_m1_rdata, r_bus_err);
        mon(1, f_m0_valid, f_m1_valid, f_m0_ready, f_m1_ready, f_m0_rdata, f_m1_rdata, f_bus_err);
        if (r_s_valid) begin
            chk("s_addr_mux", r_s_addr, r_grant[1] ? A1 : A0);
            chk("s_wdata_mux", r_s_wdata, r_grant[1] ? W1 : W0);
            chk("s_wstrb_mux", 32'(r_s_wstrb), r_grant[1] ? 32'hF : 32'h0);
            chk("s_instr_mux", 32'(r_s_instr), r_grant[1] ? 32'd0 : 32'd1);
        end
    end

    // Wait (bounded) for the round-robin instance to complete master m, then drop its valid.
    task automatic wait_rdy(input int m);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && r_m0_ready) || (m == 1 && r_m1_ready)) got = 1'b1;
        end
        chk("ready_within_bound", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [1:0] seq_rr[12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [1:0] seq_fp[9]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b00};

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_grant", 32'(r_grant), 32'h0);
        chk("rst_s_valid", 32'(r_s_valid), 32'h0);
        chk("rst_err_count", 32'(r_err_count), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_rst_grant", 32'(r_grant), 32'h0);

        // single m0 read, slave latency 2
        lat_rr = 2;
        srd = 32'h1234_5678;
        push_rr(0, 32'h1234_5678, 1'b0);
        m0_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("s1_grant", 32'(r_grant), 32'h1);
        chk("s1_s_valid", 32'(r_s_valid), 32'h1);
        wait_rdy(0);
        chk("s1_grant_idle", 32'(r_grant), 32'h0);

        // round-robin alternation with both masters requesting
        do_reset();
        lat_rr = 1;
        srd = 32'hA5A5_0001;
        push_rr(0, srd, 1'b0); push_rr(1, srd, 1'b0);
        push_rr(0, srd, 1'b0); push_rr(1, srd, 1'b0);
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("rr_grant_seq", 32'(r_grant), 32'(seq_rr[k]));
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        // fixed priority: m1 only after m0 withdraws
        lat_fp = 1;
        push_fp(0, srd, 1'b0); push_fp(0, srd, 1'b0); push_fp(1, srd, 1'b0);
        f_m0_valid = 1'b1;
        f_m1_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("fp_grant_seq", 32'(f_grant), 32'(seq_fp[k]));
            if (k == 5) f_m0_valid = 1'b0;
        end
        f_m1_valid = 1'b0;

        // watchdog: slave never ready, error at the 5th busy cycle
        lat_rr = NEVER;
        push_rr(0, ERRW, 1'b1);
        m0_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("to_bus_err", 32'(r_bus_err), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                chk("to_s_valid_forced_low", 32'(r_s_valid), 32'd0);
                chk("to_m0_ready", 32'(r_m0_ready), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        m0_valid = 1'b0;
        chk("to_err_count_1", 32'(r_err_count), 32'd1);
        chk("to_grant_idle", 32'(r_grant), 32'd0);

        // s_ready on the timeout cycle: normal completion wins
        lat_rr = 4;
        srd = 32'h0BAD_F00D;
        push_rr(1, 32'h0BAD_F00D, 1'b0);
        m1_valid = 1'b1;
        wait_rdy(1);
        chk("coincide_err_count", 32'(r_err_count), 32'd1);

        // saturation of the error counter
        lat_rr = NEVER;
        for (int n = 0; n < 299; n++) begin
            push_rr(0, ERRW, 1'b1);
            m0_valid = 1'b1;
            wait_rdy(0);
        end
        chk("err_count_saturated", 32'(r_err_count), 32'd255);

        // reset during a busy m1 transfer
        m1_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy_grant_m1", 32'(r_grant), 32'h2);
        reset = 1'b1;
        m0_valid = 1'b1;
        @(negedge clk);
        chk("rst_during_m1_ready", 32'(r_m1_ready), 32'd0);
        chk("rst_during_s_valid", 32'(r_s_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_after_grant", 32'(r_grant), 32'd0);
        chk("rst_after_s_valid", 32'(r_s_valid), 32'd0);
        chk("rst_after_m1_ready", 32'(r_m1_ready), 32'd0);
        chk("rst_after_err_count", 32'(r_err_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lat_rr = 1;
        push_rr(0, srd, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_release_m0_wins", 32'(r_grant), 32'h1);
        m1_valid = 1'b0;
        wait_rdy(0);

        repeat (3) @(posedge clk);
        chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata, instr).
- Master 0 is the CPU and master 1 is a secondary bus master, e.g. a flash-to-RAM copy engine. The slave side drives the address-decoded RAM/ROM fabric.
- Provides round-robin or fixed-priority grant, holds the grant for a whole transfer, and has a bus-timeout watchdog that terminates hung transfers with an error word.

Parameters:
- FIXED_PRIO, 0: 1 = master 0 always wins; 0 = round-robin.
- TIMEOUT_CYCLES, 255: BUSY cycles without s_ready before forced termination; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timed-out transfer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes (0 = read)
- m0_ready  out  1  master 0 transfer done
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for master 1
- s_valid  out  1  slave request
- s_instr  out  1  slave instruction flag
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave strobes
- s_ready  in  1  slave done
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner (00 = idle)
- bus_err  out  1  one-cycle pulse on timeout
- err_count  out  8  saturating count of timeouts

Behaviour:
- Reset state: IDLE, rr_last=1 (master 0 wins the first tie), counter=0, err_count=0.
  - All outputs are 0 during and after reset, including grant, s_* and m*_ready.
- States are IDLE and BUSY.
- IDLE:
  - s_valid=0.
  - If any m*_valid is set: register the winner into grant and go to BUSY.
  - Single requester: it wins.
  - Both requesting, FIXED_PRIO=1: master 0 wins.
  - Both requesting, FIXED_PRIO=0: the master not equal to rr_last wins.
  - Arbitration costs 1 cycle; the earliest s_valid is the cycle after m*_valid rises.
- BUSY:
  - s_valid = granted master's valid.
  - s_instr/s_addr/s_wdata/s_wstrb are combinationally muxed from the granted master.
  - The non-granted master's ready stays 0, and its rdata is 0.
  - If s_ready=1: granted m*_ready=1 in the same cycle and m*_rdata=s_rdata. Then rr_last=owner, grant=00, counter=0, go to IDLE.
  - This gives a minimum of one IDLE cycle between transfers, so a back-to-back requester can never be granted twice in a row while the other is waiting (round-robin mode).
  - If the granted master drops valid before s_ready: s_valid drops the same cycle, no ready is issued, and the state returns to IDLE. rr_last is not updated.
- Watchdog:
  - Counter increments each BUSY cycle with s_ready=0. It is 8 bits wide and compared against TIMEOUT_CYCLES.
  - When the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0) and s_ready=0, in that cycle:
    - granted m*_ready=1 and m*_rdata=ERR_RDATA;
    - s_valid is forced to 0;
    - bus_err=1;
    - err_count increments, saturating at 255;
    - the state goes to IDLE with rr_last=owner.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
- Writes: wstrb passes unchanged. A timed-out write is reported only via bus_err; rdata is ignored by the master.
- Reset mid-transfer: abort immediately and return to the reset state. No ready is issued to the masters.
- m*_ready is never asserted unless the corresponding m*_valid is 1 in that cycle.

Test Plan:
- m0 read only, slave ready 2 cycles after s_valid, s_rdata=32'h1234_5678 -> s_valid at cycle+1; m0_ready pulses once with m0_rdata=32'h1234_5678; grant=01 then 00.
- Both valid continuously, FIXED_PRIO=0, slave ready after 1 cycle -> grants alternate 01,10,01,10, each grant separated by one IDLE cycle; first grant goes to m0.
- Both valid, FIXED_PRIO=1 -> m1 never granted while m0_valid stays high; m1 granted only once m0 deasserts.
- Slave never ready, TIMEOUT_CYCLES=4 -> m0_ready with m0_rdata=32'hDEAD_BEEF at the 5th BUSY cycle; bus_err single pulse; err_count=1; repeated 300 times -> err_count holds at 255.
- s_ready asserted exactly on the timeout cycle -> normal completion with s_rdata; bus_err=0; err_count unchanged.
- Reset asserted during BUSY with m1 granted -> next cycle grant=00, s_valid=0, no m1_ready; after reset release with both requesting, m0 wins.
